// File: rtl/gated_clk_en_ctrl_if.sv
// Control/status bundle between a clocked unit's requesters and its clock-enable controller.
// master = requester side, slave = gated_clk_en_ctrl.
interface gated_clk_en_ctrl_if #(
    parameter int OFF_CNT_W = 16
);
    logic                 ctrl_busy;
    logic                 ctrl_wake_req;
    logic                 ctrl_force_on;
    logic                 ctrl_cnt_clr;
    logic                 local_en;
    logic                 ctrl_wake_ack;
    logic                 ctrl_clk_off;
    logic [OFF_CNT_W-1:0] ctrl_off_cycles;

    modport master (
        output ctrl_busy, ctrl_wake_req, ctrl_force_on, ctrl_cnt_clr,
        input  local_en, ctrl_wake_ack, ctrl_clk_off, ctrl_off_cycles
    );

    modport slave (
        input  ctrl_busy, ctrl_wake_req, ctrl_force_on, ctrl_cnt_clr,
        output local_en, ctrl_wake_ack, ctrl_clk_off, ctrl_off_cycles
    );
endinterface

// File: rtl/gated_clk_en_ctrl.sv
// Idle-detect clock-enable controller for one gated clock cell. Runs on the ungated clock;
// local_en is decoded from registered state only so the gating cell never sees a glitch.
module gated_clk_en_ctrl #(
    parameter int CNT_W       = 4,
    parameter int IDLE_CYCLES = 8,
    parameter int OFF_CNT_W   = 16
) (
    input  logic               forever_cpuclk,
    input  logic               cpurst_b,
    gated_clk_en_ctrl_if.slave ctrl
);
    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_IDLE_WAIT = 2'd1,
        ST_OFF       = 2'd2,
        ST_WAKE      = 2'd3
    } state_e;

    // Terminal count truncated to CNT_W so IDLE_CYCLES == 2**CNT_W compares at all ones.
    localparam logic [CNT_W-1:0] IDLE_TERM = CNT_W'(IDLE_CYCLES - 1);

    if (IDLE_CYCLES < 1 || IDLE_CYCLES > (1 << CNT_W)) begin : g_bad_cfg
        $error("gated_clk_en_ctrl: IDLE_CYCLES=%0d outside 1..2**CNT_W", IDLE_CYCLES);
    end

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic [OFF_CNT_W-1:0] off_cnt_q;
    logic                 wake;

    assign wake = ctrl.ctrl_busy | ctrl.ctrl_wake_req | ctrl.ctrl_force_on;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        // NOTE: non-blocking updates keep every register sampling pre-edge values.
        if (!cpurst_b) begin
            state_q    <= ST_RUN;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (!wake) begin
                    state_d    = ST_IDLE_WAIT;
                    idle_cnt_d = '0;
                end
            end
            ST_IDLE_WAIT: begin
                // Wake beats gating, even on the terminal count.
                if (wake) begin
                    state_d    = ST_RUN;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_TERM) begin
                    state_d = ST_OFF;
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end
            ST_OFF: begin
                if (wake) state_d = ST_WAKE;
            end
            ST_WAKE: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        ctrl.local_en      = (state_q != ST_OFF);
        ctrl.ctrl_clk_off  = (state_q == ST_OFF);
        ctrl.ctrl_wake_ack = ctrl.ctrl_wake_req & (state_q != ST_OFF);
    end

    // Gated-cycle counter saturates at all ones; clear takes priority over increment.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            off_cnt_q <= '0;
        end else if (ctrl.ctrl_cnt_clr) begin
            off_cnt_q <= '0;
        end else if (state_q == ST_OFF && off_cnt_q != '1) begin
            off_cnt_q <= off_cnt_q + OFF_CNT_W'(1);
        end
    end

    assign ctrl.ctrl_off_cycles = off_cnt_q;
endmodule
